// File: rtl/dma_pkg.sv
// Shared types for the DMA channel arbitration stage.
//   prio_state_t           : one-hot arbitration FSM state
//   ch_idx_t               : channel index
//   DEFAULT_PRIORITY_ORDER : {p3,p2,p1,p0} = 3,2,1,0 (ch0 highest)
//   rotateOrder(n)         : order after channel n completes, n drops to lowest
package dma_pkg;

  typedef logic [1:0] ch_idx_t;

  typedef enum logic [3:0] {
    IDLE    = 4'b0001,
    REQ     = 4'b0010,
    GRANT   = 4'b0100,
    RELEASE = 4'b1000
  } prio_state_t;

  localparam logic [7:0] DEFAULT_PRIORITY_ORDER = 8'b11_10_01_00;

  // p0=(n+1)%4 ... p3=n; 2-bit arithmetic wraps modulo 4 for free.
  function automatic logic [7:0] rotateOrder(input ch_idx_t n);
    ch_idx_t p0, p1, p2;
    p0 = n + 2'd1;
    p1 = n + 2'd2;
    p2 = n + 2'd3;
    return {n, p2, p1, p0};
  endfunction

endpackage

// File: rtl/dma_priority_resolver_if.sv
// DREQ/HRQ/HLDA/DACK handshake bundle between the pins, the CPU bus
// and timing control.
//   slave  : the resolver (consumes DREQ/HLDA/cycleDone, drives HRQ/DACK/grant)
//   master : the environment driving requests and acknowledges
interface dma_priority_resolver_if;
  import dma_pkg::*;

  logic [3:0] DREQ;
  logic       HLDA;
  logic       cycleDone;
  logic       HRQ;
  logic [3:0] DACK;
  logic       grantValid;
  ch_idx_t    grantChannel;

  modport slave (
    input  DREQ, HLDA, cycleDone,
    output HRQ, DACK, grantValid, grantChannel
  );

  modport master (
    output DREQ, HLDA, cycleDone,
    input  HRQ, DACK, grantValid, grantChannel
  );

endinterface

// File: rtl/dma_priority_encoder.sv
// Combinational priority pick over 4 channels.
//   pending       in  4  request bits, already polarity-corrected and masked
//   priorityOrder in  8  {p3,p2,p1,p0}; p0 scanned first
//   any           out 1  at least one pending channel
//   winner        out 2  first pending channel in scan order (0 when none)
module dma_priority_encoder
  import dma_pkg::*;
(
  input  logic [3:0] pending,
  input  logic [7:0] priorityOrder,
  output logic       any,
  output ch_idx_t    winner
);

  always_comb begin
    any    = 1'b0;
    winner = '0;
    for (int i = 0; i < 4; i++) begin
      if (!any && pending[priorityOrder[i*2 +: 2]]) begin
        any    = 1'b1;
        winner = priorityOrder[i*2 +: 2];
      end
    end
  end

endmodule

// File: rtl/dma_priority_resolver.sv
// Channel arbitration for the 4-channel DMA controller: resolves pending
// DREQs (fixed or rotating priority), runs the HRQ/HLDA hold handshake and
// drives DACK plus the granted channel to timing control.
//   CLK, RESET_N      clock, async active-low reset
//   bus (slave)       DREQ/HLDA/cycleDone in, HRQ/DACK/grantValid/grantChannel out
//   maskReg           1 = channel never granted
//   dreqSense         0 = DREQ active-high, 1 = active-low
//   dackSense         0 = DACK active-low, 1 = active-high
//   priorityType      0 = fixed, 1 = rotating
//   controllerDisable 1 = no new HRQ
//   priorityOrder     {p3,p2,p1,p0}
module dma_priority_resolver
  import dma_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int PRIO_W = 2
) (
  input  logic                     CLK,
  input  logic                     RESET_N,
  dma_priority_resolver_if.slave   bus,
  input  logic [NUM_CH-1:0]        maskReg,
  input  logic                     dreqSense,
  input  logic                     dackSense,
  input  logic                     priorityType,
  input  logic                     controllerDisable,
  output logic [NUM_CH*PRIO_W-1:0] priorityOrder
);

  prio_state_t       state, stateNext;
  ch_idx_t           grantCh;
  logic [7:0]        orderQ;
  logic [NUM_CH-1:0] pending;
  logic [NUM_CH-1:0] dackActive;
  logic              anyPend;
  ch_idx_t           winner;

  assign pending = (dreqSense ? ~bus.DREQ : bus.DREQ) & ~maskReg;

  // Fixed mode ignores the rotation register so a mode switch takes effect
  // in the same cycle.
  assign priorityOrder = priorityType ? orderQ : DEFAULT_PRIORITY_ORDER;

  dma_priority_encoder uEnc (
    .pending       (pending),
    .priorityOrder (priorityOrder),
    .any           (anyPend),
    .winner        (winner)
  );

  // State register
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state <= IDLE;
    else          state <= stateNext;
  end

  // Next state
  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:    if (anyPend && !controllerDisable) stateNext = REQ;
      REQ: begin
        if (!anyPend)      stateNext = IDLE;
        else if (bus.HLDA) stateNext = GRANT;
      end
      // Completion and early HLDA drop both release; completion takes
      // precedence only for the rotation update below.
      GRANT:   if (bus.cycleDone || !bus.HLDA) stateNext = RELEASE;
      RELEASE: stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Winner is taken in the HLDA cycle, not when HRQ was raised.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)                               grantCh <= '0;
    else if (state == REQ && anyPend && bus.HLDA) grantCh <= winner;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)                               orderQ <= DEFAULT_PRIORITY_ORDER;
    else if (!priorityType)                     orderQ <= DEFAULT_PRIORITY_ORDER;
    else if (state == GRANT && bus.cycleDone)   orderQ <= rotateOrder(grantCh);
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : gDack
    assign dackActive[g] = (state == GRANT) && (grantCh == ch_idx_t'(g));
  end

  // Outputs
  always_comb begin
    bus.HRQ          = (state == REQ) || (state == GRANT);
    bus.grantValid   = (state == GRANT);
    bus.grantChannel = grantCh;
    bus.DACK         = dackSense ? dackActive : ~dackActive;
  end

endmodule

// File: tb/tb_dma_priority_resolver.sv
module tb_dma_priority_resolver;
  import dma_pkg::*;

  logic       CLK;
  logic       RESET_N;
  logic [3:0] maskReg;
  logic       dreqSense, dackSense, priorityType, controllerDisable;
  logic [7:0] priorityOrder;

  dma_priority_resolver_if bus ();

  dma_priority_resolver #(.NUM_CH(4), .PRIO_W(2)) dut (
    .CLK               (CLK),
    .RESET_N           (RESET_N),
    .bus               (bus),
    .maskReg           (maskReg),
    .dreqSense         (dreqSense),
    .dackSense         (dackSense),
    .priorityType      (priorityType),
    .controllerDisable (controllerDisable),
    .priorityOrder     (priorityOrder)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  // Reference model: phase 0=idle 1=requesting 2=granted 3=release gap;
  // priority list kept as an ordinary array of channel numbers, p0 first.
  int mPhase;
  int mOrd[4];
  int mCh;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic mReset();
    mPhase = 0;
    mCh    = 0;
    for (int i = 0; i < 4; i++) mOrd[i] = i;
  endtask

  function automatic bit isPending(input int c);
    bit req;
    req = dreqSense ? !bus.DREQ[c] : bus.DREQ[c];
    return req && !maskReg[c];
  endfunction

  task automatic modelEdge();
    int  eff[4];
    bit  found;
    int  win;
    if (!RESET_N) begin mReset(); return; end
    for (int i = 0; i < 4; i++) eff[i] = priorityType ? mOrd[i] : i;
    found = 0; win = 0;
    for (int i = 0; i < 4; i++)
      if (!found && isPending(eff[i])) begin found = 1; win = eff[i]; end
    case (mPhase)
      0: if (found && !controllerDisable) mPhase = 1;
      1: if (!found) mPhase = 0;
         else if (bus.HLDA) begin mCh = win; mPhase = 2; end
      2: if (bus.cycleDone) begin
           if (priorityType) for (int i = 0; i < 4; i++) mOrd[i] = (mCh + 1 + i) % 4;
           mPhase = 3;
         end else if (!bus.HLDA) mPhase = 3;
      default: mPhase = 0;
    endcase
    if (!priorityType) for (int i = 0; i < 4; i++) mOrd[i] = i;
  endtask

  task automatic compareAll();
    logic [3:0] d;
    logic [7:0] o;
    for (int c = 0; c < 4; c++) begin
      bit act;
      act  = (mPhase == 2) && (mCh == c);
      d[c] = dackSense ? act : !act;
    end
    for (int i = 0; i < 4; i++) o[i*2 +: 2] = priorityType ? 2'(mOrd[i]) : 2'(i);
    chk("hrq",   32'(bus.HRQ),        32'(mPhase == 1 || mPhase == 2));
    chk("gv",    32'(bus.grantValid), 32'(mPhase == 2));
    chk("dack",  32'(bus.DACK),       32'(d));
    chk("gch",   32'(bus.grantChannel), 32'(mCh));
    chk("order", 32'(priorityOrder),  32'(o));
  endtask

  task automatic step();
    @(posedge CLK);
    modelEdge();
    #1;
    compareAll();
  endtask

  task automatic waitGrant(input string tag);
    int n = 0;
    while (!bus.grantValid && n < 10) begin step(); n++; end
    chk(tag, 32'(bus.grantValid), 32'd1);
  endtask

  initial begin
    logic [7:0] savedOrd;
    RESET_N = 1'b0;
    bus.DREQ = 4'h0; bus.HLDA = 1'b0; bus.cycleDone = 1'b0;
    maskReg = 4'h0; dreqSense = 1'b0; dackSense = 1'b0;
    priorityType = 1'b0; controllerDisable = 1'b0;
    mReset();
    #2;
    chk("rst_hrq",   32'(bus.HRQ), 32'd0);
    chk("rst_gv",    32'(bus.grantValid), 32'd0);
    chk("rst_gch",   32'(bus.grantChannel), 32'd0);
    chk("rst_dack",  32'(bus.DACK), 32'hF);
    chk("rst_order", 32'(priorityOrder), 32'hE4);
    #10 RESET_N = 1'b1;

    // 1: fixed priority, DREQ=0110 -> channel 1
    dackSense = 1'b1;
    bus.DREQ = 4'b0110;
    step();
    chk("t1_hrq", 32'(bus.HRQ), 32'd1);
    bus.HLDA = 1'b1;
    step();
    chk("t1_gch",  32'(bus.grantChannel), 32'd1);
    chk("t1_dack", 32'(bus.DACK), 32'b0010);
    bus.cycleDone = 1'b1;
    step();
    chk("t1_rel_dack", 32'(bus.DACK), 32'b0000);
    bus.cycleDone = 1'b0; bus.HLDA = 1'b0; bus.DREQ = 4'h0;
    step();

    // 2: rotating, all requesting -> 0,1,2,3,0
    priorityType = 1'b1;
    bus.DREQ = 4'hF; bus.HLDA = 1'b1;
    for (int k = 0; k < 5; k++) begin
      waitGrant("t2_wait");
      chk("t2_gch", 32'(bus.grantChannel), 32'(k % 4));
      bus.cycleDone = 1'b1;
      step();
      bus.cycleDone = 1'b0;
      if (k == 0) chk("t2_order", 32'(priorityOrder), 32'b00_11_10_01);
    end
    bus.DREQ = 4'h0; bus.HLDA = 1'b0; priorityType = 1'b0;
    step(); step();

    // 3: masked request never raises HRQ
    bus.DREQ = 4'b0001; maskReg = 4'b0001;
    for (int k = 0; k < 20; k++) begin
      step();
      chk("t3_masked_hrq", 32'(bus.HRQ), 32'd0);
    end
    maskReg = 4'b0000;
    step();
    chk("t3_unmask_hrq", 32'(bus.HRQ), 32'd1);
    bus.DREQ = 4'h0;
    step();

    // 4: one-cycle DREQ pulse, no HLDA
    bus.DREQ = 4'b0100;
    step();
    chk("t4_hrq_hi", 32'(bus.HRQ), 32'd1);
    bus.DREQ = 4'h0;
    step();
    chk("t4_hrq_lo", 32'(bus.HRQ), 32'd0);
    chk("t4_dack",   32'(bus.DACK), 32'h0);
    step();

    // 5: async reset in the middle of a grant on ch2
    priorityType = 1'b1;
    bus.DREQ = 4'b0100; bus.HLDA = 1'b1;
    waitGrant("t5_wait");
    chk("t5_gch", 32'(bus.grantChannel), 32'd2);
    #2 RESET_N = 1'b0;
    #1;
    mReset();
    chk("t5_hrq",   32'(bus.HRQ), 32'd0);
    chk("t5_dack",  32'(bus.DACK), 32'h0);
    chk("t5_order", 32'(priorityOrder), 32'hE4);
    bus.DREQ = 4'h0; bus.HLDA = 1'b0;
    step();
    RESET_N = 1'b1;
    step();

    // 6: early HLDA drop on ch3 -> release gap, no rotation, then re-request
    bus.DREQ = 4'b1000; bus.HLDA = 1'b1;
    waitGrant("t6_wait");
    chk("t6_gch", 32'(bus.grantChannel), 32'd3);
    savedOrd = priorityOrder;
    bus.HLDA = 1'b0;
    step();
    chk("t6_gv",    32'(bus.grantValid), 32'd0);
    chk("t6_dack",  32'(bus.DACK), 32'h0);
    chk("t6_order", 32'(priorityOrder), 32'(savedOrd));
    step();
    step();
    chk("t6_rehrq", 32'(bus.HRQ), 32'd1);
    bus.DREQ = 4'h0;
    step(); step();

    // Randomized traffic against the model
    for (int k = 0; k < 1500; k++) begin
      bus.DREQ          = 4'($urandom);
      maskReg           = 4'($urandom & $urandom);
      bus.HLDA          = ($urandom_range(0, 3) != 0);
      bus.cycleDone     = ($urandom_range(0, 3) == 0);
      controllerDisable = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 49) == 0) priorityType = ~priorityType;
      if ($urandom_range(0, 99) == 0) dreqSense    = ~dreqSense;
      if ($urandom_range(0, 99) == 0) dackSense    = ~dackSense;
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
